// File: rtl/poly_pkg.sv
// Shared definitions for the two-operand coefficient streamer:
// default sizing, bank-select encodings and the streamer FSM states.
package poly_pkg;

    localparam int Q    = 17;   // coefficient modulus
    localparam int N    = 8;    // coefficients per polynomial
    localparam int LOGQ = 5;    // coefficient width
    localparam int LOGN = 3;    // index width, N == 2**LOGN

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/poly_coeff_bank.sv
// Operand A/B coefficient storage: one write port, two asynchronous reads
// at a shared index. Storage is never reset.
// Optional macro POLY_STREAM_REDUCE_EN: reduce write data modulo q before
// it is stored; otherwise data is stored verbatim.
module poly_coeff_bank import poly_pkg::*; #(
    parameter int COEF_Q = Q,
    parameter int COEF_N = N,
    parameter int COEF_W = LOGQ,
    parameter int IDX_W  = LOGN
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [COEF_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [COEF_W-1:0] rd_a,
    output logic [COEF_W-1:0] rd_b
);

    logic [COEF_W-1:0] r_bank_a [COEF_N];
    logic [COEF_W-1:0] r_bank_b [COEF_N];
    logic [COEF_W-1:0] w_wdata;
    logic              w_hit_a;
    logic              w_hit_b;

`ifdef POLY_STREAM_REDUCE_EN
    assign w_wdata = COEF_W'(32'(wr_data) % COEF_Q);
`else
    assign w_wdata = wr_data;
`endif

    // A write landing at the index being read is forwarded, so a write and
    // a start in the same cycle stream the freshly written value.
    assign w_hit_a = wr_en && (wr_sel == SEL_A) && (wr_addr == rd_idx);
    assign w_hit_b = wr_en && (wr_sel == SEL_B) && (wr_addr == rd_idx);
    assign rd_a    = w_hit_a ? w_wdata : r_bank_a[rd_idx];
    assign rd_b    = w_hit_b ? w_wdata : r_bank_b[rd_idx];

    // Single write port into the selected bank.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_sel == SEL_A) r_bank_a[wr_addr] <= w_wdata;
            else                 r_bank_b[wr_addr] <= w_wdata;
        end
    end

endmodule

// File: rtl/poly_pair_streamer.sv
// Streams N (A[i], B[i]) coefficient pairs over valid/ready after start.
// Valid and data are registered and never depend on out_ready.
// Optional macro POLY_STREAM_REDUCE_EN is handled inside poly_coeff_bank.
module poly_pair_streamer import poly_pkg::*; #(
    parameter int COEF_Q = Q,
    parameter int COEF_N = N,
    parameter int COEF_W = LOGQ,
    parameter int IDX_W  = LOGN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [COEF_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              out0_valid,
    output logic              out1_valid,
    output logic [COEF_W-1:0] poly_out0,
    output logic [COEF_W-1:0] poly_out1,
    input  logic              out_ready
);

    state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt, w_rd_idx;
    logic              r_valid, w_valid_nxt;
    logic [COEF_W-1:0] r_out0, r_out1, w_out0_nxt, w_out1_nxt;
    logic [COEF_W-1:0] w_rd_a, w_rd_b;
    logic              w_wr_en, w_xfer, w_last;

    assign w_wr_en  = wr_en && (r_state == IDLE);
    assign w_xfer   = r_valid && out_ready;
    assign w_last   = (r_idx == IDX_W'(COEF_N - 1));
    // While streaming, look one ahead so the next pair is ready on transfer.
    assign w_rd_idx = (r_state == STREAM) ? r_idx + 1'b1 : '0;

    poly_coeff_bank #(
        .COEF_Q (COEF_Q),
        .COEF_N (COEF_N),
        .COEF_W (COEF_W),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_idx  (w_rd_idx),
        .rd_a    (w_rd_a),
        .rd_b    (w_rd_b)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state, index and output-register updates.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_out0_nxt  = r_out0;
        w_out1_nxt  = r_out1;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = STREAM;
                    w_idx_nxt   = '0;
                    w_valid_nxt = 1'b1;
                    w_out0_nxt  = w_rd_a;
                    w_out1_nxt  = w_rd_b;
                end
            end
            STREAM: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_state_nxt = DONE;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_idx_nxt  = r_idx + 1'b1;
                        w_out0_nxt = w_rd_a;
                        w_out1_nxt = w_rd_b;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Index, valid and output data registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_out0  <= '0;
            r_out1  <= '0;
        end else begin
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_out0  <= w_out0_nxt;
            r_out1  <= w_out1_nxt;
        end
    end

    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign out0_valid = r_valid;
    assign out1_valid = r_valid;
    assign poly_out0  = r_out0;
    assign poly_out1  = r_out1;

endmodule

// File: tb/tb_poly_pair_streamer.sv
// Self-checking bench for poly_pair_streamer: table-driven streams, random
// streams against a bank model, plus reset-abort and busy-write sequences.
module tb_poly_pair_streamer;

    localparam int NC = 8;
    localparam int QM = 17;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic       wr_sel;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic       start;
    logic       busy, done, out0_valid, out1_valid;
    logic [4:0] poly_out0, poly_out1;
    logic       out_ready;

    int checks = 0;
    int errors = 0;
    int ma [NC];
    int mb [NC];

    typedef struct {
        int         a [NC];
        int         b [NC];
        logic [7:0] rdy;       // ready pattern, bit k%8 on stream cycle k
        int         exp_prod;  // expected (a*b) mod q per pair, -1 = skip
        int         exp_cyc;   // expected stream cycles, -1 = skip
    } vec_t;

    vec_t tbl [3];

    poly_pair_streamer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .out0_valid (out0_valid),
        .out1_valid (out1_valid),
        .poly_out0  (poly_out0),
        .poly_out1  (poly_out1),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    function automatic int mdl(input int d);
`ifdef POLY_STREAM_REDUCE_EN
        return d % QM;
`else
        return d;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wr(input bit sel, input int addr, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 3'(addr);
        wr_data = 5'(data);
        @(negedge clk);
        wr_en   = 1'b0;
        if (sel) mb[addr] = mdl(data);
        else     ma[addr] = mdl(data);
    endtask

    task automatic load(input int a [NC], input int b [NC]);
        for (int i = 0; i < NC; i++) begin
            wr(1'b0, i, a[i]);
            wr(1'b1, i, b[i]);
        end
    endtask

    // One start-to-idle stream, every cycle checked against the model.
    // sw: write A[0]=sw_d in the start cycle. inj: write A[0]=9 plus start
    // in stream cycle 2, both of which must be dropped.
    task automatic run_stream(input logic [7:0] pat, input int exp_prod,
                              input bit sw, input int sw_d, input bit inj,
                              output int ncyc);
        int  xf;
        bit  fin;
        int  ea [NC];
        int  eb [NC];
        xf   = 0;
        fin  = 1'b0;
        ncyc = 0;
        if (sw) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = 5'(sw_d);
            ma[0] = mdl(sw_d);
        end
        ea = ma;
        eb = mb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            wr_en   = inj && (cyc == 2);
            start   = inj && (cyc == 2);
            wr_sel  = 1'b0;
            wr_addr = 3'd0;
            wr_data = 5'd9;
            if (xf == NC) begin
                chk("done_pulse", int'(done), 1);
                chk("valid_after_last", int'(out0_valid), 0);
                chk("busy_in_done", int'(busy), 1);
                fin = 1'b1;
                out_ready = 1'b0;
            end else begin
                ncyc++;
                chk("valid0", int'(out0_valid), 1);
                chk("valid1", int'(out1_valid), 1);
                chk("busy", int'(busy), 1);
                chk("no_early_done", int'(done), 0);
                chk($sformatf("pairA[%0d]", xf), int'(poly_out0), ea[xf]);
                chk($sformatf("pairB[%0d]", xf), int'(poly_out1), eb[xf]);
                if (exp_prod >= 0)
                    chk("mult_mod_q", (int'(poly_out0) * int'(poly_out1)) % QM, exp_prod);
                out_ready = pat[cyc % 8];
                if (out_ready) xf++;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        start = 1'b0;
        if (!fin) chk("stream_timeout", xf, NC);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_valid", int'(out0_valid), 0);
    endtask

    initial begin
        int ncyc;
        int ra [NC];
        int rb [NC];
        logic [7:0] pat;

        for (int i = 0; i < NC; i++) begin
            tbl[0].a[i] = i + 1; tbl[0].b[i] = 2;
            tbl[1].a[i] = i + 1; tbl[1].b[i] = 2;
            tbl[2].a[i] = 16;    tbl[2].b[i] = 16;
        end
        tbl[0].rdy = 8'hFF; tbl[0].exp_prod = -1; tbl[0].exp_cyc = 8;
        tbl[1].rdy = 8'h49; tbl[1].exp_prod = -1; tbl[1].exp_cyc = 20;
        tbl[2].rdy = 8'hFF; tbl[2].exp_prod = 1;  tbl[2].exp_cyc = 8;

        reset_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0;
        wr_data = '0; start = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(out0_valid), 0);
        chk("rst_out0", int'(poly_out0), 0);
        chk("rst_out1", int'(poly_out1), 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            load(tbl[v].a, tbl[v].b);
            run_stream(tbl[v].rdy, tbl[v].exp_prod, 1'b0, 0, 1'b0, ncyc);
            chk($sformatf("vec%0d_cycles", v), ncyc, tbl[v].exp_cyc);
        end

        // Reset during the 4th transfer aborts with no done pulse.
        load(tbl[0].a, tbl[0].b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_pair", int'(poly_out0), ma[3]);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b0;
        chk("abort_valid", int'(out0_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_out0", int'(poly_out0), 0);
        @(negedge clk);
        chk("abort_no_done", int'(done), 0);
        run_stream(8'hFF, -1, 1'b0, 0, 1'b0, ncyc);

        // Write and start during a stream are dropped; old A[0] survives.
        run_stream(8'hFF, -1, 1'b0, 0, 1'b1, ncyc);
        run_stream(8'hFF, -1, 1'b0, 0, 1'b0, ncyc);
        chk("busy_write_dropped", 1 - int'(ma[0] == 9), 1);

        // Write and start in the same idle cycle: the write is streamed.
        run_stream(8'hFF, -1, 1'b1, 13, 1'b0, ncyc);

        // Out-of-range write: reduced under the macro, verbatim otherwise.
        wr(1'b0, 0, 20);
        run_stream(8'hFF, -1, 1'b0, 0, 1'b0, ncyc);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NC; i++) begin
                ra[i] = int'($urandom_range(0, QM - 1));
                rb[i] = int'($urandom_range(0, QM - 1));
            end
            load(ra, rb);
            pat = 8'($urandom_range(0, 255)) | 8'h01;
            run_stream(pat, -1, 1'b0, 0, 1'b0, ncyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/poly_pair_streamer.md
Name: poly_pair_streamer

Overview:
- Source end of the element-wise pipeline's two-operand coefficient stream.
- Holds two N-coefficient polynomials (operand A, operand B), loaded through a simple write port.
- On start, streams N coefficient pairs, index 0 to N-1, over FIFO-like valid/ready ports into the element-wise multiplier input side. Reports busy/done to the controller.

Parameters:
- q, 17, coefficient modulus.
- N, 8, coefficients per polynomial.
- logq, 5, coefficient width in bits.
- logN, 3, index width in bits (N == 2**logN).

Ports:
- clk  input  1  clock.
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- wr_en  input  1  coefficient write strobe.
- wr_sel  input  1  selects bank: 0 = operand A, 1 = operand B.
- wr_addr  input  logN  coefficient index to write.
- wr_data  input  logq  coefficient value.
- start  input  1  request to begin streaming.
- busy  output  1  high while streaming.
- done  output  1  one-cycle pulse after the last pair is accepted.
- out0_valid  output  1  operand A coefficient valid.
- out1_valid  output  1  operand B coefficient valid (always equal to out0_valid).
- poly_out0  output  logq  operand A coefficient.
- poly_out1  output  logq  operand B coefficient.
- out_ready  input  1  consumer accepts the current pair.

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE, index 0, busy 0, done 0, out0_valid/out1_valid 0, poly_out0/poly_out1 0.
  - Coefficient storage is not cleared.
  - Reset mid-stream aborts immediately; no done pulse.
- FSM states: IDLE, STREAM, DONE.
  - IDLE + start: go to STREAM, index <= 0, valids <= 1, poly_out0/1 <= bankA[0]/bankB[0] (registered). Latency start -> first valid = 1 cycle.
  - STREAM, transfer (out0_valid && out_ready) with index < N-1: index++, present the next pair next cycle. Valids stay high, giving back-to-back throughput of 1 pair/clk.
  - STREAM, transfer with index == N-1: valids <= 0, go to DONE.
  - STREAM, no transfer: outputs hold. Data and valid must not change until accepted.
  - DONE: done = 1 for exactly one cycle, then IDLE. start in DONE is ignored.
- Valid must never depend combinationally on out_ready. The consumer's ready depends on valid, so this rule prevents a combinational loop.
- busy = 1 in STREAM and DONE.
- start while busy: ignored.
- Writes:
  - Accepted only in IDLE; wr_en while busy is dropped.
  - A write and start in the same IDLE cycle: the write lands first, and the streamed data includes it.
- Exactly N transfers per start. Index wraps to 0 on return to IDLE.

Optional Feature:
- Macro POLY_STREAM_REDUCE_EN.
  - Defined: wr_data is reduced modulo q before storage, so streamed coefficients are always < q.
  - Undefined: wr_data is stored verbatim (caller guarantees < q); no modulo logic.

Decomposition:
- Shared package/header poly_pkg: FSM state encodings (IDLE/STREAM/DONE), default q/N/logq/logN localparams, bank-select constants (SEL_A=0, SEL_B=1).
- One sub-module, poly_coeff_bank:
  - Two N x logq register arrays.
  - Single write port (sel/addr/data, reduction under the macro).
  - Dual asynchronous read at a common index.
- Top level holds the FSM, index counter and output registers.

Test Plan:
- Load A=[1..8], B=[2,2,...,2]; start; out_ready tied 1 -> pairs (1,2)...(8,2) on 8 consecutive cycles starting 1 cycle after start; done pulse 1 cycle after the 8th transfer.
- Same load, out_ready toggling 1,0,0,1,... -> each pair held stable while not ready; exactly 8 transfers; order preserved; no duplicates.
- Connect to elementwise_multiplier (q=17); A=[16]*8, B=[16]*8 -> multiplier outputs 1 eight times (256 mod 17).
- Assert reset_n low at transfer 4 -> next cycle valids 0, busy 0, no done; a fresh start streams from index 0 with the original data.
- wr_en (A, addr 0, data 9) and start during STREAM -> write dropped, start ignored; a later stream shows the old A[0].
- POLY_STREAM_REDUCE_EN defined: write 20 -> streamed value 3; undefined: streamed 20.
